// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM type, accumulator-width helper and default latency for systolic_engine
// Contents: state_t (LOAD/COMPUTE/DRAIN), default_aw(dw,row), DEF_ROW/DEF_COL, LAT
package systolic_pkg;
    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
    localparam int DEF_ROW = 4;
    localparam int DEF_COL = 4;
    localparam int LAT     = DEF_ROW + DEF_COL;
    // Full-precision width: a DWxDW product plus one growth bit per doubling of rows, plus a guard bit
    function automatic int default_aw(input int dw, input int row);
        return 2 * dw + $clog2(row) + 1;
    endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one weight-stationary multiply-accumulate cell of the systolic array
// Ports: clk_in clock; i_adv global advance; i_w_load/i_w stationary weight load;
//        i_x/o_x feature in and registered pass-through to the right;
//        i_psum/o_psum partial sum from above and registered sum passed down
module systolic_pe #(
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic                 clk_in,
    input  logic                 i_adv,
    input  logic                 i_w_load,
    input  logic signed [DW-1:0] i_w,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [AW-1:0] i_psum,
    output logic signed [DW-1:0] o_x,
    output logic signed [AW-1:0] o_psum
);
    logic signed [DW-1:0] r_w;
    logic signed [AW-1:0] w_prod;
    // Operands sign-extended to AW first; AW >= 2*DW keeps the product exact
    assign w_prod = AW'(r_w) * AW'(i_x);
    always_ff @(posedge clk_in) begin
        if (i_w_load) begin
            r_w <= i_w;
        end
        if (i_adv) begin
            o_x    <= i_x;
            o_psum <= i_psum + w_prod;
        end
    end
endmodule

// File: rtl/systolic_engine.sv
// systolic_engine: parametrised weight-stationary systolic matrix-vector engine, y[c] = sum_r x[r]*W[r][c]
// Ports: clk_in/rst_in clock and sync active-high reset;
//        w_valid/w_ready/w_data weight row stream (one row per beat, element c at [c*DW +: DW]);
//        f_valid/f_ready/f_last/f_data feature vector stream (f_last closes the weight tile);
//        o_valid/o_ready/o_data result stream (y[c] at [c*AW +: AW]); busy high unless idle in LOAD
module systolic_engine
    import systolic_pkg::*;
#(
    parameter int ROW = DEF_ROW,
    parameter int COL = DEF_COL,
    parameter int DW  = 8,
    parameter int AW  = default_aw(DW, ROW)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [COL*DW-1:0] w_data,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic              f_last,
    input  logic [ROW*DW-1:0] f_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [COL*AW-1:0] o_data,
    output logic              busy
);
    localparam int WCW = (ROW > 1) ? $clog2(ROW) : 1;
    // Token stages ahead of the output register: ROW rows, then COL-1 columns of alignment
    localparam int NV  = ROW + COL - 1;

    state_t            r_state;
    logic [WCW-1:0]    r_wcnt;
    logic              r_w_ready;
    logic              r_busy;
    logic              r_o_valid;
    logic [NV-1:0]     r_v;
    logic [COL*AW-1:0] r_o_data;
    logic              w_adv;
    logic              w_wbeat;
    logic              w_acc;
    logic              w_drained;

    logic signed [DW-1:0] w_xs [ROW];
    logic signed [DW-1:0] w_xi [ROW][COL];
    logic signed [DW-1:0] w_xo [ROW][COL];
    logic signed [AW-1:0] w_pi [ROW][COL];
    logic signed [AW-1:0] w_ps [ROW][COL];
    logic [COL*AW-1:0]    w_y;
    logic [ROW*DW-1:0]    w_x_unused;

    // A held output freezes the whole pipeline, so every stage moves in lockstep
    assign w_adv     = !(r_o_valid && !o_ready);
    assign w_wbeat   = w_valid && r_w_ready;
    assign w_acc     = f_valid && f_ready;
    assign w_drained = (r_v == '0) && (!r_o_valid || o_ready);
    assign w_ready   = r_w_ready;
    assign f_ready   = (r_state == COMPUTE) && w_adv;
    assign o_valid   = r_o_valid;
    assign o_data    = r_o_data;
    assign busy      = r_busy;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= LOAD;
            r_wcnt    <= '0;
            r_w_ready <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_wbeat) begin
                        r_busy <= 1'b1;
                        if (r_wcnt == WCW'(ROW - 1)) begin
                            r_wcnt    <= '0;
                            r_state   <= COMPUTE;
                            r_w_ready <= 1'b0;
                        end else begin
                            r_wcnt <= r_wcnt + WCW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (w_acc && f_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state   <= LOAD;
                        r_w_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_v       <= '0;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
        end else if (w_adv) begin
            r_v[0] <= w_acc;
            for (int i = 1; i < NV; i++) begin
                r_v[i] <= r_v[i-1];
            end
            r_o_valid <= r_v[NV-1];
            if (r_v[NV-1]) begin
                r_o_data <= w_y;
            end
        end
    end

    // Input skew: element r waits r stages so it meets the partial sum coming down column 0
    for (genvar r = 0; r < ROW; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign w_xs[r] = f_data[r*DW +: DW];
        end else begin : g_delay
            logic signed [DW-1:0] r_sk [r];
            always_ff @(posedge clk_in) begin
                if (w_adv) begin
                    r_sk[0] <= f_data[r*DW +: DW];
                    for (int i = 1; i < r; i++) begin
                        r_sk[i] <= r_sk[i-1];
                    end
                end
            end
            assign w_xs[r] = r_sk[r-1];
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row
        for (genvar c = 0; c < COL; c++) begin : g_col
            if (c == 0) begin : g_xl
                assign w_xi[r][c] = w_xs[r];
            end else begin : g_xm
                assign w_xi[r][c] = w_xo[r][c-1];
            end
            if (r == 0) begin : g_pt
                assign w_pi[r][c] = '0;
            end else begin : g_pm
                assign w_pi[r][c] = w_ps[r-1][c];
            end
            if (c == COL - 1) begin : g_xe
                assign w_x_unused[r*DW +: DW] = w_xo[r][c];
            end
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk_in  (clk_in),
                .i_adv   (w_adv),
                .i_w_load(w_wbeat && (r_wcnt == WCW'(r))),
                .i_w     (w_data[c*DW +: DW]),
                .i_x     (w_xi[r][c]),
                .i_psum  (w_pi[r][c]),
                .o_x     (w_xo[r][c]),
                .o_psum  (w_ps[r][c])
            );
        end
    end

    // Output de-skew: column c finishes c cycles after column 0, so it waits COL-1-c stages
    for (genvar c = 0; c < COL; c++) begin : g_deskew
        if (c == COL - 1) begin : g_direct
            assign w_y[c*AW +: AW] = w_ps[ROW-1][c];
        end else begin : g_delay
            localparam int DEP = COL - 1 - c;
            logic [AW-1:0] r_ds [DEP];
            always_ff @(posedge clk_in) begin
                if (w_adv) begin
                    r_ds[0] <= w_ps[ROW-1][c];
                    for (int i = 1; i < DEP; i++) begin
                        r_ds[i] <= r_ds[i-1];
                    end
                end
            end
            assign w_y[c*AW +: AW] = r_ds[DEP-1];
        end
    end
endmodule

// File: tb/tb_systolic_engine.sv
// tb_systolic_engine: directed self-checking bench for systolic_engine (4x4 main instance, 2x2 worked example)
module tb_systolic_engine;
    localparam int DW  = 8;
    localparam int AW  = 19;
    localparam int AW2 = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        w_valid = 1'b0, f_valid = 1'b0, f_last = 1'b0, o_ready = 1'b1;
    logic        w_ready, f_ready, o_valid, busy;
    logic [31:0] w_data = '0, f_data = '0;
    logic [75:0] o_data;

    logic        a_w_valid = 1'b0, a_f_valid = 1'b0, a_f_last = 1'b0;
    logic        a_w_ready, a_f_ready, a_o_valid, a_busy;
    logic [15:0] a_w_data = '0, a_f_data = '0;
    logic [35:0] a_o_data;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          W [4][4];
    logic [31:0] xs [16];

    systolic_engine #(.ROW(4), .COL(4), .DW(DW)) dut (
        .clk_in(clk), .rst_in(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_last(f_last), .f_data(f_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .busy(busy)
    );

    systolic_engine #(.ROW(2), .COL(2), .DW(DW)) dut2 (
        .clk_in(clk), .rst_in(rst),
        .w_valid(a_w_valid), .w_ready(a_w_ready), .w_data(a_w_data),
        .f_valid(a_f_valid), .f_ready(a_f_ready), .f_last(a_f_last), .f_data(a_f_data),
        .o_valid(a_o_valid), .o_ready(1'b1), .o_data(a_o_data), .busy(a_busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint y_of(input logic [75:0] d, input int c);
        logic signed [AW-1:0] v;
        v = d[c*AW +: AW];
        return v;
    endfunction

    function automatic longint model(input logic [31:0] x, input int c);
        longint s = 0;
        for (int r = 0; r < 4; r++) begin
            s += longint'($signed(x[r*8 +: 8])) * longint'(W[r][c]);
        end
        return s;
    endfunction

    function automatic logic [31:0] pack_row(input int r);
        logic [31:0] d;
        for (int c = 0; c < 4; c++) begin
            d[c*8 +: 8] = 8'(W[r][c]);
        end
        return d;
    endfunction

    task automatic load_w();
        for (int r = 0; r < 4; r++) begin
            w_valid = 1'b1;
            w_data  = pack_row(r);
            check("load_wrdy", w_ready, 1);
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic single(input logic [31:0] x, input longint exp, input string tag);
        int n;
        o_ready = 1'b1;
        f_valid = 1'b1;
        f_last  = 1'b1;
        f_data  = x;
        check({tag, "_frdy"}, f_ready, 1);
        tick();
        f_valid = 1'b0;
        f_last  = 1'b0;
        n = 1;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 8);
        for (int c = 0; c < 4; c++) begin
            check({tag, "_y"}, y_of(o_data, c), exp);
        end
        tick();
        check({tag, "_wrdy_after"}, w_ready, 1);
        check({tag, "_ov_after"}, o_valid, 0);
    endtask

    task automatic run_stream(input int n, input int stall_at, input bit wjunk, input string tag);
        int i = 0, j = 0, first_acc = -1, first_out = -1, last_out = -1;
        logic [75:0] held = '0;
        for (int t = 0; t < 80; t++) begin
            f_valid = (i < n);
            f_data  = (i < n) ? xs[i] : '0;
            f_last  = (i == n - 1);
            o_ready = !(stall_at >= 0 && t >= stall_at && t < stall_at + 5);
            w_valid = wjunk && (j < n);
            w_data  = $urandom;
            #1;
            if (w_valid) check({tag, "_wrdy_busy"}, w_ready, 0);
            if (!o_ready) begin
                check({tag, "_stall_frdy"}, f_ready, 0);
                check({tag, "_stall_ov"}, o_valid, 1);
                if (t == stall_at) held = o_data;
                else check({tag, "_stall_hold"}, longint'(o_data == held), 1);
            end
            if (f_valid && f_ready) begin
                if (i == 0) first_acc = t;
                i++;
            end
            if (o_valid && o_ready) begin
                if (j < n) begin
                    if (j == 0) first_out = t;
                    last_out = t;
                    for (int c = 0; c < 4; c++) begin
                        check({tag, "_y"}, y_of(o_data, c), model(xs[j], c));
                    end
                end
                j++;
            end
            tick();
        end
        f_valid = 1'b0;
        f_last  = 1'b0;
        w_valid = 1'b0;
        o_ready = 1'b1;
        check({tag, "_count"}, j, n);
        check({tag, "_first_lat"}, first_out - first_acc, 8);
        check({tag, "_span"}, last_out - first_acc, n - 1 + 8 + (stall_at >= 0 ? 5 : 0));
        check({tag, "_wrdy_end"}, w_ready, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_w_ready", w_ready, 1);
        check("rst_f_ready", f_ready, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", longint'(o_data == '0), 1);
        check("rst_busy", busy, 0);
        check("rst2_w_ready", a_w_ready, 1);
        rst = 1'b0;

        // 2x2 worked example: W0=[1,2], W1=[3,4], x=[5,6] -> y=[23,34]
        a_w_valid = 1'b1;
        a_w_data  = {8'd2, 8'd1};
        tick();
        a_w_data  = {8'd4, 8'd3};
        tick();
        a_w_valid = 1'b0;
        check("t2_frdy", a_f_ready, 1);
        a_f_valid = 1'b1;
        a_f_last  = 1'b1;
        a_f_data  = {8'd6, 8'd5};
        tick();
        a_f_valid = 1'b0;
        a_f_last  = 1'b0;
        check("t2_wrdy_drain", a_w_ready, 0);
        tick();
        check("t2_ov_e1", a_o_valid, 0);
        tick();
        check("t2_ov_e2", a_o_valid, 0);
        tick();
        check("t2_ov_e3", a_o_valid, 1);
        check("t2_y0", longint'($signed(a_o_data[AW2-1:0])), 23);
        check("t2_y1", longint'($signed(a_o_data[2*AW2-1:AW2])), 34);
        check("t2_busy", a_busy, 1);
        tick();
        check("t2_ov_done", a_o_valid, 0);
        check("t2_wrdy_done", a_w_ready, 1);
        check("t2_busy_done", a_busy, 0);

        // Signed corners at 4x4
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) W[r][c] = -128;
        load_w();
        check("neg_busy", busy, 1);
        check("neg_wrdy", w_ready, 0);
        single({4{8'h80}}, 65536, "neg");
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) W[r][c] = 127;
        load_w();
        single({4{8'h80}}, -65024, "mix");

        // Back-to-back stream with random weights and features
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) W[r][c] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 16; i++) xs[i] = $urandom;
        load_w();
        run_stream(16, -1, 1'b0, "s1");

        // Same weights, output stall mid-stream and weight beats offered while busy
        load_w();
        for (int i = 0; i < 16; i++) xs[i] = $urandom;
        run_stream(16, 12, 1'b1, "s2");

        // Reset with three vectors in flight
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) W[r][c] = int'($urandom_range(255)) - 128;
        load_w();
        f_last = 1'b1;
        tick();
        f_last = 1'b0;
        check("rs_lone_last", f_ready, 1);
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1;
            f_data  = $urandom;
            check("rs_frdy", f_ready, 1);
            tick();
        end
        f_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_o_valid", o_valid, 0);
        check("rs_w_ready", w_ready, 1);
        check("rs_f_ready", f_ready, 0);
        check("rs_busy", busy, 0);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) W[r][c] = r * 4 + c - 7;
        load_w();
        xs[0] = $urandom;
        run_stream(1, -1, 1'b0, "rs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/systolic_engine.md
# systolic_engine

Parametrised weight-stationary systolic matrix-vector engine, the successor of the fixed 4x4 array in the CNN accelerator datapath. It owns the input skew and output de-skew registers, a weight-preload state machine and valid/ready handshakes on every stream. Each accepted feature vector x of ROW signed elements produces one output vector y[c] = sum over r of x[r]*W[r][c], with COL full-precision signed sums. It sits between the feature line buffer and the accumulation/activation stage.

## Interface
- ROW, 4, PE rows (feature vector length), ≥1
- COL, 4, PE columns (output vector length), ≥1
- DW, 8, signed width of features and weights
- AW, 2*DW+$clog2(ROW)+1, signed accumulator/output width; must be ≥ 2*DW
- clk_in  input  1  clock, all logic rising-edge
- rst_in  input  1  reset; one clock, reset is synchronous and active-high
- w_valid  input  1  weight row beat valid
- w_ready  output  1  engine accepts a weight row
- w_data  input  COL*DW  weight row r; element c at bits [c*DW +: DW]
- f_valid  input  1  feature vector valid
- f_ready  output  1  engine accepts a feature vector
- f_last  input  1  marks the last vector of the current weight tile
- f_data  input  ROW*DW  element r at bits [r*DW +: DW]
- o_valid  output  1  output vector valid
- o_ready  input  1  downstream accepts output
- o_data  output  COL*AW  y[c] at bits [c*AW +: AW]
- busy  output  1  high in any state other than LOAD with a zero weight row count

## Operation
- FSM states LOAD, COMPUTE, DRAIN; reset state LOAD.
- LOAD: w_ready=1, f_ready=0. Each w_valid&w_ready beat writes row wcnt of the stationary weights, wcnt++. The beat with wcnt==ROW-1 clears wcnt and moves to COMPUTE.
- COMPUTE: w_ready=0, f_ready=adv. An f_valid&f_ready beat injects the vector. If f_last is set on that beat, move to DRAIN.
- DRAIN: w_ready=0, f_ready=0. Move to LOAD once no valid token remains in the pipeline and the output register is empty or being consumed that cycle.
- Weights never change while a token is in flight. That is guaranteed by DRAIN.
- Global advance: adv = !(o_valid && !o_ready). When adv=0, every skew, PE, de-skew and valid register holds.
- Arithmetic: signed DW×DW product sign-extended to AW. Partial sums accumulate in AW with two's-complement wrap. Wrap cannot occur at the default AW.
- Element r of the input is delayed r stages before PE(r,0). Features move one PE right per advance, partial sums one PE down. Column c is delayed COL-1-c stages after the last row, so all COL results align.
- A token-valid bit travels with the pipeline. The bubble cycles between vectors carry valid=0 and produce no output.
- Reset at any point: FSM to LOAD, wcnt=0, every valid bit cleared, in-flight vectors discarded. Weight and data registers need no reset.

## Timing
- Reset values: w_ready=1, f_ready=0, o_valid=0, o_data=0, busy=0.
- Latency: a vector accepted on edge k gives o_valid=1 with its result after edge k+ROW+COL-1, i.e. ROW+COL edges counting the accepting one, when there are no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one vector per cycle in COMPUTE with o_ready=1.
- o_valid/o_data stay stable while o_ready=0. Outputs appear in input order.
- First f_ready=1 comes in the cycle after the last weight beat.
- Back-to-back tiles: the first weight beat of the next tile can be accepted in the cycle after the last result leaves, via LOAD.
- f_last with f_valid=0 or f_ready=0 is ignored.

## Structure
- Package systolic_pkg holds:
  - the state_t enum {LOAD, COMPUTE, DRAIN},
  - a function for the default AW,
  - localparam LAT = ROW+COL.
- Sub-module systolic_pe, instantiated ROW×COL times:
  - registered feature pass-through plus registered psum_out = psum_in + x*w,
  - stationary weight register with a load enable,
  - an advance enable input.
- The top level holds the FSM, wcnt, skew/de-skew shift registers, the valid pipeline, and the handshake logic.

## Test plan
- ROW=COL=2, DW=8. Load rows W0=[1,2] and W1=[3,4], then send x=[5,6] with f_last. Expect o_data=[23,34] exactly 4 edges after acceptance, then a return to LOAD with w_ready=1.
- Signed corner, default params: all weights -128 and x all -128. Expect every y[c]=65536. Also W all 127 and x all -128: expect every y[c]=-65024.
- Stream 16 random vectors back-to-back at 4x4 with o_ready=1. Expect one output per cycle matching a reference model, in order, first result at latency 8.
- Drive o_ready low for 5 cycles mid-stream. Expect f_ready=0 and o_data to stay stable during the stall, with no loss or duplication; total latency grows by 5.
- Assert w_valid during COMPUTE and DRAIN. Expect w_ready=0 and the weights unchanged; the results of the current tile use the old weights.
- Pulse rst_in for one cycle while 3 vectors are in flight. Next cycle expect o_valid=0, w_ready=1 and f_ready=0; expect no stale output after a new weight load and vector.
